// File: rtl/example_pkg.sv
// Shared types and defaults for the example_unit registered ALU slice.
package example_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_e;

  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/example_logic_unit.sv
// Combinational operation decode for example_unit; produces result and carry.
// Build option EXAMPLE_SAT_EN: ADD saturates to all ones and flags overflow on carry.
module example_logic_unit
  import example_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    unique case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_ADD: begin
`ifdef EXAMPLE_SAT_EN
        // Overflow clamps to the largest representable value; carry marks it.
        result    = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
`else
        result    = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
`endif
      end
      default: begin
        result    = '0;
        carry_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/example_unit.sv
// Registered two-operand logic/arithmetic unit with carry and zero flags.
// Build option EXAMPLE_SAT_EN selects saturating ADD in example_logic_unit.
module example_unit
  import example_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  op_e              op,
  input  logic             valid_i,
  output logic [WIDTH-1:0] C,
  output logic             valid_o,
  output logic             carry,
  output logic             zero
);

  // Handshake: valid_i is accepted on every rising edge it is high (there is
  // no ready); valid_o pulses for exactly one cycle per accepted input, and
  // C/carry/zero hold their last values while valid_i is low.

  logic [WIDTH-1:0] next_result;
  logic             next_carry;

  example_logic_unit #(
    .WIDTH(WIDTH)
  ) u_logic (
    .a        (A),
    .b        (B),
    .op       (op),
    .result   (next_result),
    .carry_out(next_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      C       <= '0;
      carry   <= 1'b0;
      zero    <= 1'b1;
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        C     <= next_result;
        carry <= next_carry;
        zero  <= (next_result == '0);
      end
    end
  end

endmodule

// File: tb/tb_example_unit.sv
// Directed bench for example_unit: expected {carry,zero,C} queued at drive time, popped on valid_o.
module tb_example_unit;
  import example_pkg::*;

  localparam int W = DEF_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  op_e          op;
  logic         valid_i;
  logic [W-1:0] C;
  logic         valid_o;
  logic         carry;
  logic         zero;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_exp;
  int           checks   = 0;
  int           failures = 0;

  example_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .op     (op),
    .valid_i(valid_i),
    .C      (C),
    .valid_o(valid_o),
    .carry  (carry),
    .zero   (zero)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Reference model: returns {carry, zero, C}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, b, input op_e o);
    logic [W-1:0] r;
    logic         cy;
    int           s;
    cy = 1'b0;
    case (o)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: begin
        s  = int'(a) + int'(b);
        cy = (s >= (1 << W));
        r  = W'(s % (1 << W));
`ifdef EXAMPLE_SAT_EN
        if (cy) r = {W{1'b1}};
`endif
      end
    endcase
    return {cy, (r == '0), r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v);
    logic [W+1:0] e;
    chk({tag, ".valid_o"}, 32'(valid_o), 32'(v));
    if (v) begin
      if (exp_q.size() == 0) begin
        chk({tag, ".queue_empty"}, 32'(1), 32'(0));
      end else begin
        e        = exp_q.pop_front();
        last_exp = e;
      end
    end
    chk({tag, ".C"}, 32'(C), 32'(last_exp[W-1:0]));
    chk({tag, ".carry"}, 32'(carry), 32'(last_exp[W+1]));
    chk({tag, ".zero"}, 32'(zero), 32'(last_exp[W]));
  endtask

  // driver: apply one cycle of stimulus, then check after the edge
  task automatic step(input string tag, input logic [W-1:0] a, b, input op_e o, input logic v);
    A       = a;
    B       = b;
    op      = o;
    valid_i = v;
    if (v) exp_q.push_back(model(a, b, o));
    @(posedge clk);
    #1;
    check_out(tag, v);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".C"}, 32'(C), 32'(0));
    chk({tag, ".valid_o"}, 32'(valid_o), 32'(0));
    chk({tag, ".carry"}, 32'(carry), 32'(0));
    chk({tag, ".zero"}, 32'(zero), 32'(1));
  endtask

  initial begin
    logic [W-1:0] iv;
    last_exp = {1'b0, 1'b1, {W{1'b0}}};
    A = '0; B = '0; op = OP_AND; valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_state("reset_initial");
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_out("post_reset_idle", 1'b0);

    // invect sweeps with B = ~A
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 8; i++) begin
        iv = W'(i);
        step($sformatf("sweep_op%0d_%0d", k, i), iv, ~iv, op_e'(k), 1'b1);
      end
    end

    // ADD overflow boundary
    step("add_overflow", 4'b1001, 4'b1000, OP_ADD, 1'b1);
    step("add_max_nowrap", 4'b0111, 4'b1000, OP_ADD, 1'b1);
    step("add_all_ones", 4'b1111, 4'b1111, OP_ADD, 1'b1);
    step("add_zero_wrap", 4'b1000, 4'b1000, OP_ADD, 1'b1);

    // hold: C=0101 then three idle cycles
    step("make_0101", 4'b0101, 4'b0000, OP_OR, 1'b1);
    for (int i = 0; i < 3; i++) step($sformatf("hold_%0d", i), 4'hF, 4'hF, OP_ADD, 1'b0);

    // random back-to-back traffic with sporadic gaps
    for (int i = 0; i < 40; i++) begin
      step($sformatf("rand_%0d", i), W'($urandom_range(0, 15)), W'($urandom_range(0, 15)),
           op_e'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end

    // mid-stream reset with valid_i held high
    A = 4'h3; B = 4'h4; op = OP_ADD; valid_i = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk_reset_state("reset_mid_immediate");
    exp_q.delete();
    last_exp = {1'b0, 1'b1, {W{1'b0}}};
    @(posedge clk);
    #1;
    chk_reset_state("reset_mid_held");
    #2;
    rst = 1'b0;
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    check_out("after_reset_idle", 1'b0);
    step("after_reset_add", 4'h3, 4'h4, OP_ADD, 1'b1);
    step("after_reset_xor", 4'hA, 4'hA, OP_XOR, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
